// File: rtl/bounce_gen_pkg.sv
// bounce_gen_pkg: shared FSM states and jitter LFSR constants for the bounce emulator
package bounce_gen_pkg;
  typedef enum logic [1:0] {IDLE, TOGGLE, SETTLE} state_e;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/bounce_gen_if.sv
// bounce_gen_if: clean level in, bouncing level and status out
interface bounce_gen_if #(parameter int PERIOD_W = 7);
  logic                in;
  logic [PERIOD_W-1:0] half_period;
  logic                out;
  logic                busy;
  logic                done;
  modport master (output in, half_period, input out, busy, done);
  modport slave (input in, half_period, output out, busy, done);
endinterface

// File: rtl/bounce_lfsr.sv
// bounce_lfsr: 16-bit Galois LFSR for interval jitter, used only with BOUNCE_GEN_JITTER_EN
module bounce_lfsr import bounce_gen_pkg::*; #(
  parameter int                JIT_W = 3,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             step_i,
  output logic [JIT_W-1:0] jit_o
);
  logic [LFSR_W-1:0] lfsr_q;
  // advance one step per interval load
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) lfsr_q <= SEED;
    else if (step_i) lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
  assign jit_o = lfsr_q[JIT_W-1:0];
endmodule

// File: rtl/bounce_gen.sv
// bounce_gen: switch bounce emulator; define BOUNCE_GEN_JITTER_EN for LFSR interval jitter
module bounce_gen import bounce_gen_pkg::*; #(
  parameter int                PERIOD_W      = 7,
  parameter int                BOUNCE_COUNT  = 10,
  parameter int                SETTLE_CYCLES = 16,
  parameter int                JIT_W         = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input logic         clk,
  input logic         rstn,
  bounce_gen_if.slave bus
);
  localparam int CW = PERIOD_W + 1;
  localparam int TL_W = $clog2(2 * BOUNCE_COUNT + 2);
  localparam logic [TL_W-1:0] TOG_N = TL_W'(2 * BOUNCE_COUNT + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);
  if (LFSR_SEED == '0) begin : g_seed_chk
    $error("LFSR_SEED must be nonzero");
  end
  if (JIT_W > PERIOD_W || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 2 ** CW) begin : g_width_chk
    $error("counter too narrow for interval jitter or settle time");
  end
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, ival, jit;
  logic [TL_W-1:0]   tog_q, tog_d;
  logic              out_q, out_d, lvl_q, lvl_d, busy_q, busy_d, done_q, done_d;
  logic [PERIOD_W-1:0] hp;
  assign hp = bus.half_period;
`ifdef BOUNCE_GEN_JITTER_EN
  logic             load;
  logic [JIT_W-1:0] jit_raw;
  assign load = (state_q == IDLE && bus.in != lvl_q) ||
                (state_q == TOGGLE && cnt_q == '0 && tog_q != TL_W'(1));
  bounce_lfsr #(.JIT_W(JIT_W), .SEED(LFSR_SEED)) u_lfsr (
    .clk(clk), .rstn(rstn), .step_i(load), .jit_o(jit_raw)
  );
  assign jit = CW'(jit_raw);
`else
  assign jit = '0;
`endif
  assign ival = CW'(hp == '0 ? PERIOD_W'(1) : hp) + jit - CW'(1);
  // sequence FSM: wait for a level change, toggle 2C+1 times, then settle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    out_d   = out_q;
    lvl_d   = lvl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:
        if (bus.in != lvl_q) begin
          cnt_d   = ival;
          tog_d   = TOG_N;
          busy_d  = 1'b1;
          state_d = TOGGLE;
        end
      TOGGLE:
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          out_d = !out_q;
          tog_d = tog_q - TL_W'(1);
          cnt_d = tog_q == TL_W'(1) ? SETTLE_LD : ival;
          lvl_d = tog_q == TL_W'(1) ? !lvl_q : lvl_q;
          state_d = tog_q == TL_W'(1) ? SETTLE : TOGGLE;
        end
      SETTLE:
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset abandons any sequence without a done pulse
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tog_q   <= '0;
      out_q   <= 1'b0;
      lvl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      out_q   <= out_d;
      lvl_q   <= lvl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: directed vectors for bounce_gen (default and BOUNCE_COUNT=0 instances)
module tb_bounce_gen;
  logic       clk = 1'b0, rstn = 1'b0, in_r = 1'b0;
  logic [6:0] hp_r = 7'd4;
  int         total = 0, bad = 0;
  int         tog_a[$], tog_v1[$];
  typedef struct {
    logic       lvl;
    logic [6:0] hp;
    int         ival;
    int         done_a;
    int         done_b;
  } vec_t;
  vec_t v[6];
  bounce_gen_if ifa ();
  bounce_gen_if ifb ();
  assign ifa.in = in_r;
  assign ifb.in = in_r;
  assign ifa.half_period = hp_r;
  assign ifb.half_period = hp_r;
  bounce_gen dut_a (.clk(clk), .rstn(rstn), .bus(ifa));
  bounce_gen #(.BOUNCE_COUNT(0)) dut_b (.clk(clk), .rstn(rstn), .bus(ifb));
  always begin
    #12 clk = 1'b1;
    #13 clk = 1'b0;
  end
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input string tag, input logic lvl, input logic [6:0] hp,
                     input int ival, input int done_a, input int done_b);
    int   nb = 0, da = -1, db = -1, tb1 = -1, nda = 0, ndb = 0, bt = 0, bb = 0, d, limit;
    logic pa, pb;
    @(negedge clk);
    in_r = lvl;
    hp_r = hp;
    pa = ifa.out;
    pb = ifb.out;
    tog_a.delete();
    limit = 21 * (ival + 7) + 40;
    @(posedge clk);
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk);
      #1;
      if (ifa.out !== pa) begin tog_a.push_back(n); pa = ifa.out; end
      if (ifb.out !== pb) begin nb++; if (tb1 < 0) tb1 = n; pb = ifb.out; end
      if (ifa.done === 1'b1) begin
        nda++;
        if (da < 0) da = n;
        if (ifa.busy !== 1'b0) bb++;
      end else if (da < 0 && ifa.busy !== 1'b1) bb++;
      if (ifb.done === 1'b1) begin ndb++; if (db < 0) db = n; end
    end
    for (int j = 0; j < tog_a.size(); j++) begin
      d = tog_a[j] - (j > 0 ? tog_a[j-1] : 0);
`ifdef BOUNCE_GEN_JITTER_EN
      if (d < ival || d > ival + 7) bt++;
`else
      if (d != ival) bt++;
`endif
    end
    chk({tag, "_ntog_a"}, tog_a.size(), 21);
    chk({tag, "_interval_a"}, bt, 0);
    chk({tag, "_ndone_a"}, nda, 1);
    chk({tag, "_busy_a"}, bb, 0);
    chk({tag, "_out_a"}, int'(ifa.out), int'(lvl));
    chk({tag, "_ntog_b"}, nb, 1);
    chk({tag, "_ndone_b"}, ndb, 1);
    chk({tag, "_out_b"}, int'(ifb.out), int'(lvl));
`ifdef BOUNCE_GEN_JITTER_EN
    chk({tag, "_done_a"}, da, (tog_a.size() > 0 ? tog_a[tog_a.size()-1] : 0) + 16);
    chk({tag, "_done_b"}, db, tb1 + 16);
`else
    chk({tag, "_done_a"}, da, done_a);
    chk({tag, "_done_b"}, db, done_b);
    chk({tag, "_tog_b"}, tb1, ival);
`endif
  endtask
  initial begin
    int bad_r = 0, nd = 0, d1 = -1, d2 = -1, mism = 0;
    logic o1 = 1'b0;
    v[0] = '{1'b1, 7'd4, 4, 100, 20};
    v[1] = '{1'b0, 7'd4, 4, 100, 20};
    v[2] = '{1'b1, 7'd1, 1, 37, 17};
    v[3] = '{1'b0, 7'd0, 1, 37, 17};
    v[4] = '{1'b1, 7'd7, 7, 163, 23};
    v[5] = '{1'b0, 7'd127, 127, 2683, 143};
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      in_r = n[0];
      hp_r = 7'($urandom_range(0, 127));
      if (ifa.out !== 1'b0 || ifa.busy !== 1'b0 || ifa.done !== 1'b0) bad_r++;
      if (ifb.out !== 1'b0 || ifb.busy !== 1'b0 || ifb.done !== 1'b0) bad_r++;
    end
    chk("rst_out", int'(ifa.out), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_done", int'(ifa.done), 0);
    chk("rst_quiet", bad_r, 0);
    in_r = 1'b0;
    hp_r = 7'd4;
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("idle_busy", int'(ifa.busy), 0);
    for (int i = 0; i < 6; i++) begin
      run($sformatf("vec%0d", i), v[i].lvl, v[i].hp, v[i].ival, v[i].done_a, v[i].done_b);
      if (i == 0) tog_v1 = tog_a;
    end
    @(negedge clk);
    in_r = 1'b1;
    hp_r = 7'd4;
    @(posedge clk);
    for (int n = 1; n <= 520; n++) begin
      @(posedge clk);
      #1;
      if (n == 10) in_r = 1'b0;
      if (ifa.done === 1'b1) begin
        nd++;
        if (nd == 1) begin d1 = n; o1 = ifa.out; end
        else if (nd == 2) d2 = n;
      end
    end
    chk("glitch_ndone", nd, 2);
    chk("glitch_out_rise", int'(o1), 1);
    chk("glitch_out_fall", int'(ifa.out), 0);
`ifdef BOUNCE_GEN_JITTER_EN
    chk("glitch_order", int'(d2 > d1), 1);
`else
    chk("glitch_done1", d1, 100);
    chk("glitch_done2", d2, 201);
`endif
    @(negedge clk);
    in_r = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    bad_r = 0;
    #5 rstn = 1'b0;
    #1;
    chk("midrst_out", int'(ifa.out), 0);
    chk("midrst_busy", int'(ifa.busy), 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || ifa.out !== 1'b0) bad_r++;
    end
    chk("midrst_quiet", bad_r, 0);
    @(posedge clk);
    #2 rstn = 1'b1;
    run("after_rst", 1'b1, 7'd4, 4, 100, 20);
    mism = (tog_a.size() != tog_v1.size()) ? 1 : 0;
    for (int j = 0; j < tog_a.size() && j < tog_v1.size(); j++)
      if (tog_a[j] != tog_v1[j]) mism++;
    chk("repeat_times", mism, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
